// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUD register window on the
// CPU data bus, a small TX FIFO, and a four-state serialiser driving a registered tx.
module mmio_uart_tx #(
    parameter logic [15:0] BASE_ADDR    = 16'hC000,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] BAUD_DIV_RST = 16'd434
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        mm_we,
    input  logic        mm_re,
    output logic [15:0] rdata,
    output logic        hit,
    output logic        tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    state_t        state_q, state_d;
    logic          tx_q, tx_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   cnt_q, cnt_d;
    logic [15:0]   bit_div_q, bit_div_d;
    logic [15:0]   baud_q, baud_d;
    logic          overflow_q, overflow_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    fifo_mem_q [FIFO_DEPTH];

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic in_window;
    logic wr_txdata;
    logic wr_baud;
    logic rd_status;

    always_comb begin
        in_window = (addr[15:2] == BASE_ADDR[15:2]);
        wr_txdata = mm_we && in_window && (addr[1:0] == REG_TXDATA);
        wr_baud   = mm_we && in_window && (addr[1:0] == REG_BAUD);
        rd_status = mm_re && in_window && (addr[1:0] == REG_STATUS);
    end

    // ------------------------------------------------------------------
    // FIFO status and read mux
    // ------------------------------------------------------------------
    logic       fifo_full;
    logic       fifo_empty;
    logic       idle;
    logic [2:0] status_cnt;
    logic [7:0] fifo_head;

    always_comb begin
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        idle       = fifo_empty && (state_q == S_IDLE);
        status_cnt = 3'(count_q);
        fifo_head  = fifo_mem_q[rd_ptr_q];
    end

    always_comb begin
        hit   = mm_re && in_window;
        rdata = 16'h0000;
        if (hit) begin
            case (addr[1:0])
                REG_STATUS: rdata = {9'd0, status_cnt, 1'b0, overflow_q, fifo_full, idle};
                REG_BAUD:   rdata = baud_q;
                default:    rdata = 16'h0000;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Serialiser FSM and baud counter
    // ------------------------------------------------------------------
    logic        pop;
    logic        bit_end;
    logic [15:0] eff_div;

    always_comb begin
        // A zero divisor would never reach a bit boundary, so it runs as 1.
        eff_div = (baud_q == 16'd0) ? 16'd1 : baud_q;
        bit_end = (cnt_q == (bit_div_q - 16'd1));

        state_d   = state_q;
        tx_d      = tx_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        bit_div_d = bit_div_q;
        pop       = 1'b0;

        // The bit period is latched only at boundaries, so a BAUD write never
        // stretches or truncates the bit already on the line.
        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;
            if (bit_end) begin
                bit_div_d = eff_div;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_d   = S_START;
                    shift_d   = fifo_head;
                    tx_d      = 1'b0;
                    cnt_d     = 16'd0;
                    bit_div_d = eff_div;
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = S_START;
                        shift_d = fifo_head;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers, overflow flag and divisor register
    // ------------------------------------------------------------------
    logic push_ok;
    logic ovf_set;

    always_comb begin
        // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
        push_ok = wr_txdata && (!fifo_full || pop);
        ovf_set = wr_txdata && fifo_full && !pop;

        wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end

        overflow_d = overflow_q;
        if (rd_status) begin
            overflow_d = 1'b0;
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end

        baud_d = wr_baud ? wdata : baud_q;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values computed before this edge, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
            cnt_q      <= 16'd0;
            bit_div_q  <= 16'd1;
            baud_q     <= BAUD_DIV_RST;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            cnt_q      <= cnt_d;
            bit_div_q  <= bit_div_d;
            baud_q     <= baud_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; the count and pointers gate
    // every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q] <= wdata[7:0];
        end
    end

    assign tx = tx_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx: register-access vector table plus
// hand-timed sequences for framing, FIFO overflow, divisor change and reset.
module tb_mmio_uart_tx;

    localparam int TRACE_LEN = 8192;
    localparam logic [15:0] A_TX   = 16'hC000;
    localparam logic [15:0] A_STAT = 16'hC001;
    localparam logic [15:0] A_BAUD = 16'hC002;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        mm_we;
    logic        mm_re;
    logic [15:0] rdata;
    logic        hit;
    logic        tx;

    int checks = 0;
    int failures = 0;

    mmio_uart_tx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr),
        .wdata (wdata),
        .mm_we (mm_we),
        .mm_re (mm_re),
        .rdata (rdata),
        .hit   (hit),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    // tx sampled 1 ns after every rising edge; trace[n] is the line after edge n.
    bit trace [TRACE_LEN];
    int cyc = 0;
    always @(posedge clk) begin
        #1;
        if (cyc < TRACE_LEN) trace[cyc] = tx;
        cyc++;
    end

    typedef struct packed {
        logic        we;
        logic        re;
        logic [15:0] a;
        logic [15:0] d;
        logic        exp_hit;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit tr(input int i);
        if (i < 0 || i >= TRACE_LEN) return 1'b1;
        return trace[i];
    endfunction

    function automatic int find_fall(input int from, input int len);
        for (int i = from; i < from + len; i++) begin
            if (tr(i) == 1'b0) return i;
        end
        return -1;
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        mm_we = 1'b1;
        @(negedge clk);
        mm_we = 1'b0;
        addr  = 16'h0000;
        wdata = 16'h0000;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic h);
        addr  = a;
        mm_re = 1'b1;
        #1;
        d = rdata;
        h = hit;
        @(negedge clk);
        mm_re = 1'b0;
        addr  = 16'h0000;
    endtask

    task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] exp);
        logic [15:0] d;
        logic        h;
        bus_read(a, d, h);
        check(name, d, exp);
    endtask

    // Segments 0..n_a-1 last div_a cycles, the rest div_b (segment 0 = start, 9 = stop).
    task automatic check_frame(input string name, input int start, input logic [7:0] exp,
                               input int div_a, input int n_a, input int div_b,
                               output int next);
        int         idx;
        int         d;
        bit         shape_ok;
        bit         lvl;
        logic [7:0] got;
        idx      = start;
        shape_ok = 1'b1;
        got      = 8'h00;
        for (int s = 0; s < 10; s++) begin
            d   = (s < n_a) ? div_a : div_b;
            lvl = tr(idx);
            for (int k = 0; k < d; k++) begin
                if (tr(idx + k) != lvl) shape_ok = 1'b0;
            end
            if (s == 0 && lvl != 1'b0) shape_ok = 1'b0;
            if (s == 9 && lvl != 1'b1) shape_ok = 1'b0;
            if (s >= 1 && s <= 8) got[s-1] = lvl;
            idx += d;
        end
        check({name, "_shape"}, {31'd0, shape_ok}, 32'd1);
        check({name, "_data"}, {24'd0, got}, {24'd0, exp});
        next = idx;
    endtask

    initial begin
        int          w;
        int          s;
        int          rel;
        logic [15:0] d;
        logic        h;

        vecs[0]  = '{1'b0, 1'b1, 16'hC001, 16'h0000, 1'b1, 16'h0001};
        vecs[1]  = '{1'b1, 1'b0, 16'hC002, 16'h0004, 1'b0, 16'h0000};
        vecs[2]  = '{1'b0, 1'b1, 16'hC002, 16'h0000, 1'b1, 16'h0004};
        vecs[3]  = '{1'b1, 1'b0, 16'hC006, 16'h0009, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 16'hC002, 16'h0000, 1'b1, 16'h0004};
        vecs[5]  = '{1'b0, 1'b1, 16'hC006, 16'h0000, 1'b0, 16'h0000};
        vecs[6]  = '{1'b1, 1'b0, 16'hC003, 16'hFFFF, 1'b0, 16'h0000};
        vecs[7]  = '{1'b0, 1'b1, 16'hC003, 16'h0000, 1'b1, 16'h0000};
        vecs[8]  = '{1'b0, 1'b1, 16'hC000, 16'h0000, 1'b1, 16'h0000};
        vecs[9]  = '{1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000};
        vecs[10] = '{1'b0, 1'b1, 16'h4002, 16'h0000, 1'b0, 16'h0000};
        vecs[11] = '{1'b0, 1'b0, 16'hC002, 16'h0007, 1'b0, 16'h0000};
        vecs[12] = '{1'b0, 1'b1, 16'hC002, 16'h0000, 1'b1, 16'h0004};
        vecs[13] = '{1'b0, 1'b1, 16'hC001, 16'h0000, 1'b1, 16'h0001};

        rst_n = 1'b0;
        addr  = 16'h0000;
        wdata = 16'h0000;
        mm_we = 1'b0;
        mm_re = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_hit", {31'd0, hit}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Register access table.
        for (int i = 0; i < 14; i++) begin
            addr  = vecs[i].a;
            wdata = vecs[i].d;
            mm_we = vecs[i].we;
            mm_re = vecs[i].re;
            #1;
            check($sformatf("vec%0d_hit", i), {31'd0, hit}, {31'd0, vecs[i].exp_hit});
            check($sformatf("vec%0d_rdata", i), {16'd0, rdata}, {16'd0, vecs[i].exp_rdata});
            @(negedge clk);
            mm_we = 1'b0;
            mm_re = 1'b0;
            addr  = 16'h0000;
            wdata = 16'h0000;
        end

        // Single byte at divisor 4.
        bus_write(A_TX, 16'h00A5);
        w = cyc - 1;
        read_check("single_stat_e0", A_STAT, 16'h0010);
        read_check("single_stat_e1", A_STAT, 16'h0000);
        idle_cycles(38);
        read_check("single_stat_e40", A_STAT, 16'h0000);
        read_check("single_stat_e41", A_STAT, 16'h0001);
        check("single_tx_e0", {31'd0, tr(w)}, 32'd1);
        check("single_tx_e1", {31'd0, tr(w + 1)}, 32'd0);
        check_frame("single", w + 1, 8'hA5, 4, 10, 4, s);
        check("single_after", {31'd0, tr(s)}, 32'd1);

        // FIFO fill and overflow at divisor 8.
        bus_write(A_BAUD, 16'd8);
        bus_write(A_TX, 16'h0011);
        w = cyc - 1;
        bus_write(A_TX, 16'h0022);
        bus_write(A_TX, 16'h0033);
        bus_write(A_TX, 16'h0044);
        bus_write(A_TX, 16'h0055);
        bus_write(A_TX, 16'h0066);
        read_check("ovf_stat1", A_STAT, 16'h0046);
        read_check("ovf_stat2", A_STAT, 16'h0042);
        idle_cycles(470);
        s = w + 1;
        for (int i = 0; i < 5; i++) begin
            check_frame($sformatf("ovf_f%0d", i), s, 8'((i + 1) * 8'h11), 8, 10, 8, s);
        end
        check("ovf_no_sixth", find_fall(s, 40), 32'hFFFF_FFFF);
        read_check("ovf_stat_end", A_STAT, 16'h0001);

        // Push while full, timed onto the STOP->START pop edge.
        bus_write(A_TX, 16'h0081);
        w = cyc - 1;
        bus_write(A_TX, 16'h0082);
        bus_write(A_TX, 16'h0083);
        bus_write(A_TX, 16'h0084);
        bus_write(A_TX, 16'h0085);
        read_check("pp_stat_full", A_STAT, 16'h0042);
        idle_cycles(75);
        bus_write(A_TX, 16'h0086);
        read_check("pp_stat_after", A_STAT, 16'h0042);
        idle_cycles(520);
        s = w + 1;
        for (int i = 0; i < 6; i++) begin
            check_frame($sformatf("pp_f%0d", i), s, 8'(8'h81 + i), 8, 10, 8, s);
        end
        check("pp_no_seventh", find_fall(s, 40), 32'hFFFF_FFFF);

        // Divisor change during bit 3 of a frame.
        bus_write(A_BAUD, 16'd4);
        bus_write(A_TX, 16'h00FF);
        w = cyc - 1;
        bus_write(A_TX, 16'h0000);
        idle_cycles(17);
        bus_write(A_BAUD, 16'd2);
        idle_cycles(60);
        check_frame("div_ff", w + 1, 8'hFF, 4, 5, 2, s);
        check_frame("div_00", s, 8'h00, 2, 10, 2, s);
        check("div_no_third", find_fall(s, 20), 32'hFFFF_FFFF);
        read_check("div_baud_rd", A_BAUD, 16'h0002);

        // Divisor 0 runs as 1-cycle bits.
        bus_write(A_BAUD, 16'd0);
        read_check("div0_baud_rd", A_BAUD, 16'h0000);
        bus_write(A_TX, 16'h005A);
        w = cyc - 1;
        idle_cycles(15);
        check_frame("div0", w + 1, 8'h5A, 1, 10, 1, s);
        check("div0_after", {31'd0, tr(s)}, 32'd1);

        // Asynchronous reset mid-frame, then decode.
        bus_write(A_BAUD, 16'd8);
        bus_write(A_TX, 16'h0000);
        bus_write(A_TX, 16'h0000);
        idle_cycles(20);
        check("rst_pre_tx", {31'd0, tx}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", {31'd0, tx}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        read_check("rst_stat", A_STAT, 16'h0001);
        read_check("rst_baud", A_BAUD, 16'h01B2);
        bus_read(16'h0000, d, h);
        check("dec_0000_hit", {31'd0, h}, 32'd0);
        check("dec_0000_rdata", {16'd0, d}, 32'd0);
        bus_read(16'hC003, d, h);
        check("dec_c003_hit", {31'd0, h}, 32'd1);
        check("dec_c003_rdata", {16'd0, d}, 32'd0);
        idle_cycles(30);
        check("rst_fifo_discarded", find_fall(rel, 30), 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
